// File: rtl/lsu_bus_ctrl_pkg.sv
// Shared encodings for the load/store bus sequencer: FSM states, request
// size/type codes and the size decode helper.
// Latency: n/a (constants and a pure function). Backpressure: n/a.
package lsu_pkg;

   // FSM state encodings
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC1 = 2'd1;
   localparam logic [1:0] S_ACC2 = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   // store_size encodings (11 is illegal)
   localparam logic [1:0] ST_WORD = 2'b00;
   localparam logic [1:0] ST_HALF = 2'b01;
   localparam logic [1:0] ST_BYTE = 2'b10;

   // load_type encodings (101..111 are illegal)
   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b011;
   localparam logic [2:0] LD_LHU = 3'b100;

   // Unshifted byte masks, (1 << n) - 1 for n = 1, 2, 4 bytes
   localparam logic [3:0] MASK_BYTE = 4'b0001;
   localparam logic [3:0] MASK_HALF = 4'b0011;
   localparam logic [3:0] MASK_WORD = 4'b1111;

   typedef struct packed {
      logic       illegal;
      logic [3:0] mask;
      logic       sign;
   } size_dec_t;

   // Access size comes from store_size for stores and load_type for loads.
   function automatic size_dec_t size_decode(input logic       is_store,
                                             input logic [1:0] st_size,
                                             input logic [2:0] ld_type);
      size_dec_t d;
      d.illegal = 1'b0;
      d.mask    = MASK_WORD;
      d.sign    = 1'b0;
      if (is_store) begin
         case (st_size)
            ST_WORD: d.mask = MASK_WORD;
            ST_HALF: d.mask = MASK_HALF;
            ST_BYTE: d.mask = MASK_BYTE;
            default: d.illegal = 1'b1;
         endcase
      end else begin
         case (ld_type)
            LD_LB:   begin d.mask = MASK_BYTE; d.sign = 1'b1; end
            LD_LH:   begin d.mask = MASK_HALF; d.sign = 1'b1; end
            LD_LW:   d.mask = MASK_WORD;
            LD_LBU:  d.mask = MASK_BYTE;
            LD_LHU:  d.mask = MASK_HALF;
            default: d.illegal = 1'b1;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// Word-wide req/ack data bus between the load/store sequencer and memory.
// Latency: n/a (wires only). Backpressure: master holds req/addr/be/wdata stable until ack.
// Ports: bus_req/bus_we/bus_addr/bus_be/bus_wdata from master, bus_ack/bus_rdata from slave.
interface lsu_bus_ctrl_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/lsu_bus_ctrl_align.sv
// Byte-lane alignment: byte-enable mask, lane-shifted store data, split detect, load extension.
// Latency: combinational. Backpressure: none.
// Ports: off/size_mask/sign_ext/wdata in; rdata_lo/rdata_hi = first/second bus read words;
//        mask8/wide/split/load_ext out (upper halves of mask8/wide belong to the second access).
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [3:0]  size_mask,
   input  logic        sign_ext,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_lo,
   input  logic [31:0] rdata_hi,
   output logic [7:0]  mask8,
   output logic [63:0] wide,
   output logic        split,
   output logic [31:0] load_ext
);

   logic [4:0]  shamt;
   logic [31:0] rd_shift;

   assign shamt = {off, 3'b000};

   always_comb begin
      mask8    = {4'b0000, size_mask} << off;
      wide     = {32'h0, wdata} << shamt;
      split    = |mask8[7:4];
      // Only the low word of the shifted pair can hold the requested bytes.
      rd_shift = 32'({rdata_hi, rdata_lo} >> shamt);
      case (size_mask)
         MASK_BYTE: load_ext = {{24{sign_ext & rd_shift[7]}},  rd_shift[7:0]};
         MASK_HALF: load_ext = {{16{sign_ext & rd_shift[15]}}, rd_shift[15:0]};
         default:   load_ext = rd_shift;
      endcase
   end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store sequencer: one core access -> one or two word bus accesses, with timeout.
// Latency: accept T, bus_req T+1, mem_done T+2 (T+3 if split, T+1 on encoding error).
// Backpressure: mem_stall holds the core; bus fields stay stable until bus_ack or timeout.
// Ports: clk, reset (async, active high); mem_* core side; bus = lsu_bus_ctrl_if.master.
module lsu_bus_ctrl
   import lsu_pkg::*;
#(
   parameter bit ALLOW_MISALIGNED = 1'b1,
   parameter int TIMEOUT_CYCLES   = 255
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_valid,
   input  logic                  mem_we,
   input  logic [31:0]           mem_addr,
   input  logic [31:0]           mem_wdata,
   input  logic [1:0]            store_size,
   input  logic [2:0]            load_type,
   output logic                  mem_stall,
   output logic                  mem_done,
   output logic                  mem_err,
   output logic [31:0]           mem_rdata,
   lsu_bus_ctrl_if.master        bus
);

   // The abort fires on the last allowed cycle without ack, so bus_req is
   // high for exactly TIMEOUT_CYCLES cycles.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state;
   logic [1:0]  off_q;
   logic [3:0]  mask_q;
   logic        sign_q;
   logic        load_q;
   logic        split_q;
   logic [31:0] addr2_q;
   logic [3:0]  be2_q;
   logic [31:0] wdata2_q;
   logic [31:0] rdata1_q;
   logic [7:0]  tmo_cnt;

   logic        req_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic        done_q;
   logic        err_q;
   logic [31:0] rdata_q;

   size_dec_t   dec;
   logic        in_idle;
   logic [1:0]  a_off;
   logic [3:0]  a_mask;
   logic        a_sign;
   logic [31:0] a_rd_lo;
   logic [31:0] a_rd_hi;
   logic [7:0]  mask8;
   logic [63:0] wide;
   logic        split;
   logic [31:0] load_ext;
   logic        tmo_hit;
   logic [31:0] word_addr;

   assign dec       = size_decode(mem_we, store_size, load_type);
   assign in_idle   = (state == S_IDLE);
   assign tmo_hit   = (tmo_cnt == TMO_LAST);
   assign word_addr = {mem_addr[31:2], 2'b00};

   // One aligner serves both phases: live inputs while accepting in IDLE,
   // latched request fields while assembling load data afterwards.
   always_comb begin
      a_off   = in_idle ? mem_addr[1:0] : off_q;
      a_mask  = in_idle ? dec.mask      : mask_q;
      a_sign  = in_idle ? dec.sign      : sign_q;
      // The final ack in ACC1 means the access was not split: upper word is 0.
      a_rd_lo = (state == S_ACC2) ? rdata1_q      : bus.bus_rdata;
      a_rd_hi = (state == S_ACC2) ? bus.bus_rdata : 32'h0;
   end

   lsu_align u_align (
      .off       (a_off),
      .size_mask (a_mask),
      .sign_ext  (a_sign),
      .wdata     (mem_wdata),
      .rdata_lo  (a_rd_lo),
      .rdata_hi  (a_rd_hi),
      .mask8     (mask8),
      .wide      (wide),
      .split     (split),
      .load_ext  (load_ext)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         off_q    <= 2'b00;
         mask_q   <= 4'h0;
         sign_q   <= 1'b0;
         load_q   <= 1'b0;
         split_q  <= 1'b0;
         addr2_q  <= 32'h0;
         be2_q    <= 4'h0;
         wdata2_q <= 32'h0;
         rdata1_q <= 32'h0;
         tmo_cnt  <= 8'h0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= 32'h0;
         be_q     <= 4'h0;
         wdata_q  <= 32'h0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= 32'h0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (mem_valid) begin
                  off_q    <= mem_addr[1:0];
                  mask_q   <= dec.mask;
                  sign_q   <= dec.sign;
                  load_q   <= ~mem_we;
                  split_q  <= split;
                  addr2_q  <= word_addr + 32'd4;
                  be2_q    <= mask8[7:4];
                  wdata2_q <= wide[63:32];
                  tmo_cnt  <= 8'h0;
                  if (dec.illegal || (split && !ALLOW_MISALIGNED)) begin
                     state  <= S_DONE;
                     done_q <= 1'b1;
                     err_q  <= 1'b1;
                     if (!mem_we) rdata_q <= 32'h0;
                  end else begin
                     state   <= S_ACC1;
                     req_q   <= 1'b1;
                     we_q    <= mem_we;
                     addr_q  <= word_addr;
                     be_q    <= mask8[3:0];
                     wdata_q <= wide[31:0];
                  end
               end
            end

            S_ACC1, S_ACC2: begin
               if (bus.bus_ack) begin
                  tmo_cnt <= 8'h0;
                  if ((state == S_ACC1) && split_q) begin
                     // bus_req stays high straight into the second access
                     state    <= S_ACC2;
                     rdata1_q <= bus.bus_rdata;
                     addr_q   <= addr2_q;
                     be_q     <= be2_q;
                     wdata_q  <= wdata2_q;
                  end else begin
                     state  <= S_DONE;
                     req_q  <= 1'b0;
                     done_q <= 1'b1;
                     if (load_q) rdata_q <= load_ext;
                  end
               end else if (tmo_hit) begin
                  state  <= S_DONE;
                  req_q  <= 1'b0;
                  done_q <= 1'b1;
                  err_q  <= 1'b1;
                  if (load_q) rdata_q <= 32'h0;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.bus_req   = req_q;
   assign bus.bus_we    = we_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_be    = be_q;
   assign bus.bus_wdata = wdata_q;

   assign mem_done  = done_q;
   assign mem_err   = err_q;
   assign mem_rdata = rdata_q;
   assign mem_stall = mem_valid & ~done_q;

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
Load/store sequencer between the core's memory stage and a word-wide data bus with a req/ack handshake.
- Accepts one load or store per request and stalls the core while the access is in flight.
- Splits misaligned halfword/word accesses into two bus transactions.
- Produces byte enables and lane-shifted write data, and returns sign- or zero-extended load data.
- Flags illegal encodings and bus timeouts.

Parameters:
ALLOW_MISALIGNED, 1, 1 = split misaligned accesses into two bus accesses; 0 = misaligned access returns an error with no bus activity
TIMEOUT_CYCLES, 255, maximum number of cycles bus_req may stay high without bus_ack before the access is aborted (must be 1..255)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous active-high reset
- mem_valid  in  1  core request; held high until the cycle mem_done is high
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  32  byte address
- mem_wdata  in  32  store data, right-aligned
- store_size  in  2  00 word, 01 half, 10 byte, 11 illegal
- load_type  in  3  000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu, 101-111 illegal
- mem_stall  out  1  combinational: mem_valid & ~mem_done
- mem_done  out  1  one-cycle completion pulse
- mem_err  out  1  high with mem_done when the access failed
- mem_rdata  out  32  extended load result; registered, updated only on a load completion
- bus_req  out  1  bus request; held with stable address/data until bus_ack
- bus_we  out  1  bus write
- bus_addr  out  32  word-aligned address, bits [1:0] = 0
- bus_be  out  4  byte enables, bit i = byte lane i
- bus_wdata  out  32  lane-positioned write data
- bus_ack  in  1  access complete; bus_rdata is valid in the same cycle
- bus_rdata  in  32  read data

Behaviour:
- Reset (async, any state): state IDLE; bus_req, bus_we, bus_addr, bus_be, bus_wdata, mem_done, mem_err and mem_rdata all 0; timeout counter 0. An abandoned bus request is simply dropped.
- Access size n: 1, 2 or 4 bytes, taken from store_size (stores) or load_type (loads). off = mem_addr[1:0].
- mask8 = ((1<<n)-1) << off; bus_be for access 1 = mask8[3:0], for access 2 = mask8[7:4].
- wide = {32'b0, mem_wdata} << 8*off; access 1 writes wide[31:0], access 2 writes wide[63:32].
- split = (mask8[7:4] != 0). Access 2 address = (mem_addr & ~3) + 4, modulo 2^32 (0xFFFFFFFE wraps to 0x00000000).
- Loads: assemble {rdata2, rdata1} >> 8*off (rdata2 = 0 when not split), keep the low n bytes, sign-extend for lb/lh, zero-extend otherwise. Store completions leave mem_rdata unchanged.
- All request fields are latched at acceptance; later changes on the mem_* inputs are ignored until DONE.

State machine:
- IDLE, mem_valid=1:
  - illegal encoding, or split with ALLOW_MISALIGNED=0 -> DONE with err, no bus access.
  - otherwise -> ACC1, driving bus_req plus access-1 fields from the next cycle.
- ACC1: bus_ack -> ACC2 if split, else DONE. Timeout -> DONE with err.
- ACC2: same as ACC1 with access-2 fields; bus_req stays high continuously between the two accesses. bus_ack -> DONE.
- DONE: mem_done=1 for exactly one cycle, mem_err as flagged, next state IDLE.
  - IDLE accepts a new request in the cycle immediately after DONE (back-to-back accesses allowed).
- Timeout: the counter clears on entering ACC1/ACC2 and increments each cycle without bus_ack.
  - When the count reaches TIMEOUT_CYCLES, bus_req drops the next cycle and the access ends in DONE with err.
  - mem_rdata is forced to 0 on an errored load.
  - bus_ack in the same cycle as the limit wins: no error.
- mem_valid dropping mid-access does not cancel it (stores are not revocable); the access completes and the done pulse is still issued.
- Latency (load or store, ack in first bus cycle): accept at T, bus_req at T+1, mem_done at T+2; split accesses take T+3. Error without bus access: mem_done at T+1.

Decomposition:
- Package lsu_pkg holds:
  - state encodings IDLE/ACC1/ACC2/DONE;
  - store_size and load_type encodings;
  - helper constant for size decode.
- Sub-module lsu_align (combinational) computes mask8, wide write data, split and extended load data. lsu_bus_ctrl holds the FSM, latches and timeout counter.

Test Plan:
- lw 0x100, ack at first bus cycle with rdata 0xDEADBEEF -> bus_addr 0x100, be 1111, mem_done at T+2, mem_rdata 0xDEADBEEF, mem_stall high 2 cycles.
- sb 0x203, wdata 0x000000A5 -> single access: addr 0x200, be 1000, wdata 0xA5000000, we 1; mem_done at T+2.
- sw 0x0FE, wdata 0x11223344 -> access 1: addr 0x0FC, be 1100, wdata 0x33440000; access 2: addr 0x100, be 0011, wdata 0x00001122; mem_done at T+3.
- lh 0x107 with rdata1 0x80112233, rdata2 0x445566FF -> mem_rdata 0xFFFFFF80; lhu on the same data -> 0x0000FF80.
- TIMEOUT_CYCLES=4, lw with no ack -> bus_req high exactly 4 cycles, then mem_done=1, mem_err=1, mem_rdata 0. load_type 101 -> no bus_req, done+err at T+1.
- Reset asserted while in ACC2 -> bus_req and all outputs 0 immediately, state IDLE; a fresh lw after reset completes normally.
